// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES-128 decryption round sequencer.
// Round count, key index width, default block width and FSM states.
package aes_dec_pkg;

  localparam int NR_AES128         = 10;
  localparam int KEY_IDX_W         = 4;
  localparam int BLOCK_LENGTH_DFLT = 128;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINAL,
    DONE
  } dec_state_e;

endpackage

// File: rtl/aes_dec_round_sequencer.sv
// Iterative AES-128 decrypt controller: drives one shared inverse-round
// stage once per key NR..1, then applies the key-0 XOR itself.
// Ports: clk/rst (sync, active-low); in_* ciphertext handshake;
// out_* plaintext handshake; key_idx/key_in key store; dp_* stage; busy.
module aes_dec_round_sequencer
  import aes_dec_pkg::*;
#(
  parameter int BLOCK_LENGTH = BLOCK_LENGTH_DFLT,
  parameter int NR           = NR_AES128,
  parameter int ROUND_LAT    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_LENGTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_LENGTH-1:0] out_data,
  output logic [KEY_IDX_W-1:0]    key_idx,
  input  logic [BLOCK_LENGTH-1:0] key_in,
  output logic [BLOCK_LENGTH-1:0] dp_in,
  output logic [BLOCK_LENGTH-1:0] dp_key,
  output logic                    dp_mix_bypass,
  input  logic [BLOCK_LENGTH-1:0] dp_out,
  output logic                    busy
);

  localparam int LAT_W =
    (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT =
    LAT_W'(ROUND_LAT - 1);
  localparam logic [KEY_IDX_W-1:0] NR_IDX =
    KEY_IDX_W'(NR);

  dec_state_e state_q, state_d;

  logic [KEY_IDX_W-1:0]    round_q, round_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic [BLOCK_LENGTH-1:0] blk_q, blk_d;
  logic [BLOCK_LENGTH-1:0] dout_q, dout_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic                    byp_q, byp_d;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    lat_d   = lat_q;
    blk_d   = blk_q;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          blk_d   = in_data;
          round_d = NR_IDX;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = LAT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q != '0) begin
          lat_d = lat_q - 1'b1;
        end else begin
          blk_d   = dp_out;
          round_d = round_q - 1'b1;
          state_d = (round_d == '0) ? FINAL : ISSUE;
        end
      end
      FINAL: begin
        dout_d  = blk_q ^ key_in;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up
    // with state_q one cycle later.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    byp_d       = ((state_d == ISSUE) || (state_d == WAIT))
                  && (round_d == NR_IDX);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      round_q     <= '0;
      lat_q       <= '0;
      blk_q       <= '0;
      dout_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      byp_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      lat_q       <= lat_d;
      blk_q       <= blk_d;
      dout_q      <= dout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      byp_q       <= byp_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_data      = dout_q;
  assign key_idx       = round_q;
  assign dp_in         = blk_q;
  assign dp_key        = key_in;
  assign dp_mix_bypass = byp_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_aes_dec_round_sequencer.sv
// Bench for aes_dec_round_sequencer: models key store and inverse-round
// stage, runs FIPS-197 C.1 and related directed cases on two latencies.
module tb_aes_dec_round_sequencer;

  localparam logic [127:0] KEY =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 =
    128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index 0: ROUND_LAT=2 unit, index 1: ROUND_LAT=1 unit
  logic         in_valid [2];
  logic         out_ready [2];
  logic [127:0] in_data [2];
  logic [127:0] key_in [2];
  logic [127:0] dp_out [2];
  logic         in_ready [2];
  logic         out_valid [2];
  logic         dp_mix_bypass [2];
  logic         busy [2];
  logic [127:0] out_data [2];
  logic [127:0] dp_in [2];
  logic [127:0] dp_key [2];
  logic [3:0]   key_idx [2];

  logic         ir_a, ov_a, byp_a, bsy_a;
  logic         ir_b, ov_b, byp_b, bsy_b;
  logic [127:0] od_a, di_a, dk_a;
  logic [127:0] od_b, di_b, dk_b;
  logic [3:0]   ki_a, ki_b;

  aes_dec_round_sequencer #(.ROUND_LAT(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(ir_a),
    .in_data(in_data[0]),
    .out_valid(ov_a), .out_ready(out_ready[0]),
    .out_data(od_a),
    .key_idx(ki_a), .key_in(key_in[0]),
    .dp_in(di_a), .dp_key(dk_a),
    .dp_mix_bypass(byp_a), .dp_out(dp_out[0]),
    .busy(bsy_a)
  );

  aes_dec_round_sequencer #(.ROUND_LAT(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(ir_b),
    .in_data(in_data[1]),
    .out_valid(ov_b), .out_ready(out_ready[1]),
    .out_data(od_b),
    .key_idx(ki_b), .key_in(key_in[1]),
    .dp_in(di_b), .dp_key(dk_b),
    .dp_mix_bypass(byp_b), .dp_out(dp_out[1]),
    .busy(bsy_b)
  );

  always_comb begin
    in_ready[0] = ir_a;  in_ready[1] = ir_b;
    out_valid[0] = ov_a; out_valid[1] = ov_b;
    dp_mix_bypass[0] = byp_a;
    dp_mix_bypass[1] = byp_b;
    busy[0] = bsy_a;     busy[1] = bsy_b;
    out_data[0] = od_a;  out_data[1] = od_b;
    dp_in[0] = di_a;     dp_in[1] = di_b;
    dp_key[0] = dk_a;    dp_key[1] = dk_b;
    key_idx[0] = ki_a;   key_idx[1] = ki_b;
  end

  // ---------------- AES reference pieces ----------------
  logic [7:0]   isbox [256];
  logic [7:0]   sbx [256];
  logic [127:0] rk [16];
  logic [31:0]  w [44];
  logic [31:0]  tw;
  logic [7:0]   rc;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    logic [7:0] inv, s, r;
    inv = 8'h00;
    if (b != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gm(inv, b);
    end
    s = inv;
    r = inv;
    for (int i = 0; i < 4; i++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  // XOR key, InvMixColumns (unless bypassed), InvShiftRows, InvSubBytes
  function automatic logic [127:0] inv_round(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic byp);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] x, o;
    x = s ^ k;
    for (int n = 0; n < 16; n++) a[n] = x[127-8*n -: 8];
    if (!byp) begin
      for (int c = 0; c < 4; c++) begin
        b[4*c]   = gm(a[4*c], 8'h0e) ^ gm(a[4*c+1], 8'h0b)
                 ^ gm(a[4*c+2], 8'h0d) ^ gm(a[4*c+3], 8'h09);
        b[4*c+1] = gm(a[4*c], 8'h09) ^ gm(a[4*c+1], 8'h0e)
                 ^ gm(a[4*c+2], 8'h0b) ^ gm(a[4*c+3], 8'h0d);
        b[4*c+2] = gm(a[4*c], 8'h0d) ^ gm(a[4*c+1], 8'h09)
                 ^ gm(a[4*c+2], 8'h0e) ^ gm(a[4*c+3], 8'h0b);
        b[4*c+3] = gm(a[4*c], 8'h0b) ^ gm(a[4*c+1], 8'h0d)
                 ^ gm(a[4*c+2], 8'h09) ^ gm(a[4*c+3], 8'h0e);
      end
      a = b;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r+4*c] = a[r+4*((c+4-r)%4)];
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = isbox[b[n]];
    return o;
  endfunction

  function automatic logic [127:0] aes_dec_ref(input logic [127:0] ct);
    logic [127:0] s;
    s = ct;
    for (int k = 10; k >= 1; k--) s = inv_round(s, rk[k], k == 10);
    return s ^ rk[0];
  endfunction

  // ---------------- environment models ----------------
  logic [127:0] pipe0 [2];
  logic [127:0] pipe1 [2];

  always_comb begin
    dp_out[0] = pipe1[0];
    dp_out[1] = pipe0[1];
    for (int u = 0; u < 2; u++) key_in[u] = rk[key_idx[u]];
  end

  int cyc = 0;
  int acc_n [2] = '{0, 0};
  int acc_c [2] = '{0, 0};
  int xfer_n [2] = '{0, 0};
  int ov_n [2] = '{0, 0};

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      pipe0[u] <= inv_round(dp_in[u], dp_key[u], dp_mix_bypass[u]);
      pipe1[u] <= pipe0[u];
      if (in_valid[u] && in_ready[u]) begin
        acc_n[u] <= acc_n[u] + 1;
        acc_c[u] <= cyc;
      end
      if (out_valid[u] && out_ready[u]) xfer_n[u] <= xfer_n[u] + 1;
      if (out_valid[u]) ov_n[u] <= ov_n[u] + 1;
    end
    cyc <= cyc + 1;
  end

  logic       mon_en = 1'b0;
  int         byp_err = 0;
  logic [3:0] kseq [$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (dp_mix_bypass[0] !== (busy[0] && key_idx[0] == 4'd10))
        byp_err <= byp_err + 1;
      if (busy[0] && (kseq.size() == 0 || kseq[$] != key_idx[0]))
        kseq.push_back(key_idx[0]);
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic send(input int u, input logic [127:0] ct);
    int n0, t;
    n0 = acc_n[u];
    t = 0;
    in_data[u] = ct;
    in_valid[u] = 1'b1;
    while (acc_n[u] == n0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    in_valid[u] = 1'b0;
    check("accept", acc_n[u] - n0, 1);
  endtask

  task automatic recv(input int u, input logic [127:0] exp,
                      input int lat, input string tag);
    int t;
    t = 0;
    while (!out_valid[u] && t < 400) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_lat"}, cyc - acc_c[u], lat);
    check({tag, "_pt"}, out_data[u], exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int n0, t, a1, bad, x0, o0;
  logic [127:0] snap;

  initial begin
    for (int i = 0; i < 256; i++) sbx[i] = fwd_sbox(8'(i));
    for (int i = 0; i < 256; i++) isbox[sbx[i]] = 8'(i);
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {sbx[tw[31:24]], sbx[tw[23:16]],
              sbx[tw[15:8]], sbx[tw[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}
                        : 128'h0;

    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0;
      in_data[u] = '0;
      out_ready[u] = 1'b1;
    end

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ctl", {in_ready[0], out_valid[0], dp_mix_bypass[0],
                      busy[0], key_idx[0]}, 0);
    check("rst_out_data", out_data[0], 0);
    check("rst_dp_in", dp_in[0], 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready[0], 1);
    mon_en = 1'b1;

    // C.1 vector, ROUND_LAT=2
    kseq.delete();
    send(0, CT1);
    recv(0, PT1, 32, "c1");
    @(negedge clk);
    check("kseq_len", kseq.size(), 11);
    bad = 0;
    for (int i = 0; i < 11; i++)
      if (i < kseq.size() && kseq[i] != 4'(10 - i)) bad++;
    check("kseq_vals", bad, 0);

    // output backpressure
    out_ready[0] = 1'b0;
    send(0, CT1);
    recv(0, PT1, 32, "bp");
    snap = out_data[0];
    x0 = xfer_n[0];
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid[0] || out_data[0] !== snap || in_ready[0]) bad++;
    end
    check("bp_hold", bad, 0);
    check("bp_no_xfer", xfer_n[0] - x0, 0);
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_one_xfer", xfer_n[0] - x0, 1);
    check("bp_in_ready", in_ready[0], 1);
    check("bp_ov_low", out_valid[0], 0);

    // in_valid held through a block, then back-to-back
    n0 = acc_n[0];
    t = 0;
    in_data[0] = CT1;
    in_valid[0] = 1'b1;
    while (acc_n[0] == n0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("b2b_acc1", acc_n[0] - n0, 1);
    a1 = acc_c[0];
    in_data[0] = '0;
    recv(0, PT1, 32, "b2b1");
    t = 0;
    while (acc_n[0] - n0 < 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    in_valid[0] = 1'b0;
    check("b2b_space", acc_c[0] - a1, 33);
    recv(0, aes_dec_ref(128'h0), 32, "b2b2");
    repeat (5) @(negedge clk);
    check("b2b_accepts", acc_n[0] - n0, 2);

    // reset during cycle 15 of a block
    send(0, CT1);
    t = 0;
    while (cyc - acc_c[0] < 15 && t < 100) begin
      @(negedge clk);
      t++;
    end
    rst = 1'b0;
    @(negedge clk);
    check("mrst_ctl", {in_ready[0], out_valid[0], dp_mix_bypass[0],
                       busy[0], key_idx[0]}, 0);
    check("mrst_out_data", out_data[0], 0);
    check("mrst_dp_in", dp_in[0], 0);
    o0 = ov_n[0];
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("mrst_no_ov", ov_n[0] - o0, 0);
    send(0, CT1);
    recv(0, PT1, 32, "post_rst");
    @(negedge clk);

    // ROUND_LAT=1 unit
    send(1, CT1);
    recv(1, PT1, 22, "lat1");
    @(negedge clk);

    check("bypass_mon", byp_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_dec_round_sequencer.md
# aes_dec_round_sequencer

Iterative controller for AES-128 decryption that time-shares one inverse-round datapath stage across all rounds of a block. It accepts a ciphertext block over a valid/ready handshake, walks round keys 10 down to 0 from an external expanded-key store, and drives the shared stage once per round. It applies the final round-key XOR itself and returns plaintext over a valid/ready handshake. It sits between the block-input interface and the shared inverse-round stage; the stage is instantiated by the parent.

## Interface
- BLOCK_LENGTH, 128: block and key width.
- NR, 10: number of rounds; the key index runs NR..0.
- ROUND_LAT, 2: cycles from stage-input presentation to valid stage output. Must be ≥1.

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- in_valid  in  1  ciphertext valid
- in_ready  out  1  sequencer can accept a block
- in_data  in  BLOCK_LENGTH  ciphertext
- out_valid  out  1  plaintext valid
- out_ready  in  1  consumer accepts plaintext
- out_data  out  BLOCK_LENGTH  plaintext
- key_idx  out  4  round-key index to the key store
- key_in  in  BLOCK_LENGTH  round key for key_idx; combinational, same cycle
- dp_in  out  BLOCK_LENGTH  state to the shared stage
- dp_key  out  BLOCK_LENGTH  round key to the stage (= key_in)
- dp_mix_bypass  out  1  stage skips InvMixColumns (first step, key 10)
- dp_out  in  BLOCK_LENGTH  stage result
- busy  out  1  a block is in flight (any state except IDLE)

## Operation
- FSM states: IDLE, ISSUE, WAIT, FINAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: state_reg<=in_data, round<=NR, go to ISSUE.
- ISSUE:
  - Drive dp_in=state_reg, key_idx=round, dp_key=key_in, dp_mix_bypass=(round==NR).
  - lat_cnt<=ROUND_LAT-1, go to WAIT.
- WAIT:
  - Hold all stage inputs stable.
  - If lat_cnt!=0: decrement lat_cnt.
  - Else: state_reg<=dp_out, round<=round-1. If the new round is 0, go to FINAL; otherwise go to ISSUE.
- FINAL (key_idx=0): out_data<=state_reg^key_in, go to DONE.
- DONE:
  - out_valid=1; out_data is held stable.
  - On out_ready: go to IDLE.
- in_valid outside IDLE is ignored; in_ready=0 in those states. There is no queuing.
- key_idx equals the round register in every state.
- The stage step for keys 10..1 is: XOR key, InvMixColumns (bypassed at key 10), InvShiftRows, InvSubBytes. Key 0 is a bare XOR done in FINAL.
- round is a 4-bit register and never wraps: FINAL is entered when round reaches 0.

## Timing
- Reset values: in_ready=0 during reset (then 1 in IDLE); out_valid=0; out_data=0; key_idx=0; dp_in=0; dp_mix_bypass=0; busy=0; round=0; lat_cnt=0; FSM=IDLE.
- Cycle numbering: the accept cycle is 0.
  - Each round occupies ROUND_LAT+1 cycles.
  - FINAL is cycle 10·(ROUND_LAT+1)+1.
  - out_valid first high at cycle 10·(ROUND_LAT+1)+2, i.e. cycle 32 for ROUND_LAT=2.
- Output backpressure: out_valid and out_data are held indefinitely until out_ready. The handshake completes on the cycle out_valid&out_ready=1; in_ready=1 the following cycle.
- Minimum block period is 10·(ROUND_LAT+1)+3 cycles when out_ready is held high.
- Reset mid-operation: the next edge with rst=0 returns every register to its reset value and discards the in-flight block. No out_valid is produced for it.
- dp_out is sampled only in the last WAIT cycle of each round; its value at other times is don't-care.

## Structure
- Package aes_dec_pkg:
  - FSM state enum;
  - NR_AES128=10;
  - KEY_IDX_W=4;
  - the BLOCK_LENGTH default.
- No sub-module. The latency counter and FSM are a single always block. The shared inverse-round stage and the key store are instantiated by the parent, not inside this block.

## Test plan
- FIPS-197 C.1 vector, ROUND_LAT=2, out_ready=1:
  - Setup: key 000102030405060708090a0b0c0d0e0f (bench models the key store); in_data=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: out_data=00112233445566778899aabbccddeeff, out_valid at cycle 32.
  - Required: key_idx sequence 10,9,…,1,0; dp_mix_bypass high only while key_idx=10.
- Backpressure: out_ready=0 for 20 cycles after out_valid. Required: out_data stable, in_ready=0 throughout; one transfer after out_ready rises; in_ready=1 the next cycle.
- in_valid held high while busy with a different block. Required: no capture until IDLE; then exactly one new accept.
- Reset at cycle 15 of a block. Required: all outputs at reset values the next cycle, no out_valid. A fresh C.1 block afterwards decrypts correctly.
- ROUND_LAT=1 build. Required: the same C.1 result, with out_valid at cycle 22.
- Two back-to-back blocks (C.1 ciphertext, then all-zero ciphertext), out_ready=1. Required: both plaintexts match the reference model; accept spacing = 33 cycles.
